// File: rtl/blk_rd_stream_collector.sv
// Block-mode read stream collector: parses header/data/done framing, buffers the
// stream in a small FIFO toward the GLB, and keeps block/word counters and status flags.
module blk_rd_stream_collector #(
  parameter int unsigned               DATA_W     = 17,
  parameter int unsigned               FIFO_DEPTH = 4,
  parameter int unsigned               CNT_W      = 16,
  parameter logic [DATA_W-1:0]         DONE_TOKEN = 17'h10100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  blk_count,
  output logic [CNT_W-1:0]  word_count,
  output logic              done,
  output logic              err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_rem, w_rem_nxt;
  logic [CNT_W-1:0]  r_blk, r_word;
  logic              r_done, r_err;

  logic w_full, w_empty, w_accept, w_pop, w_push;
  logic w_is_ctrl, w_is_done;
  logic w_blk_inc, w_word_inc, w_done_set, w_err_set;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign in_ready  = clk_en && !w_full && (r_state != S_DONE);
  assign out_valid = clk_en && !w_empty;
  assign out_data  = r_mem[r_rptr[AW-1:0]];
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_is_ctrl = in_data[DATA_W-1];
  assign w_is_done = (in_data == DONE_TOKEN);

  assign blk_count  = r_blk;
  assign word_count = r_word;
  assign done       = r_done;
  assign err        = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_push      = 1'b0;
    w_blk_inc   = 1'b0;
    w_word_inc  = 1'b0;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_HDR: begin
          if (!w_is_ctrl) begin
            w_push = 1'b1;
            if (in_data[CNT_W-1:0] == '0) begin
              w_blk_inc = 1'b1;
            end else begin
              w_rem_nxt   = in_data[CNT_W-1:0];
              w_state_nxt = S_DATA;
            end
          end else if (w_is_done) begin
            w_push      = 1'b1;
            w_done_set  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_err_set = 1'b1;
          end
        end
        S_DATA: begin
          if (!w_is_ctrl) begin
            w_push     = 1'b1;
            w_word_inc = 1'b1;
            w_rem_nxt  = r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              w_blk_inc   = 1'b1;
              w_state_nxt = S_HDR;
            end
          end else if (w_is_done) begin
            w_err_set   = 1'b1;
            w_push      = 1'b1;
            w_done_set  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_err_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= S_HDR;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rem   <= '0;
      r_blk   <= '0;
      r_word  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_blk_inc  && (r_blk  != '1)) r_blk  <= r_blk  + 1'b1;
      if (w_word_inc && (r_word != '1)) r_word <= r_word + 1'b1;
      if (w_done_set) r_done <= 1'b1;
      if (w_err_set)  r_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst && !flush) r_mem[r_wptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_blk_rd_stream_collector.sv
// Self-checking bench for blk_rd_stream_collector: a cycle table for the basic
// stream plus directed sequences for backpressure, framing errors, flush/reset and clk_en.
module tb_blk_rd_stream_collector;

  localparam logic [16:0] TOK = 17'h10100;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush, in_valid, out_ready;
  logic [16:0] in_data;
  logic        in_ready, out_valid, done, err;
  logic [16:0] out_data;
  logic [15:0] blk_count, word_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned acc_cnt = 0;
  logic [16:0] out_q [$];

  blk_rd_stream_collector #(
    .DATA_W(17), .FIFO_DEPTH(4), .CNT_W(16), .DONE_TOKEN(17'h10100)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .blk_count(blk_count), .word_count(word_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (in_valid && in_ready) acc_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; clk_en = 1'b1; in_valid = 1'b0; in_data = '0;
    tick();
    rst = 1'b0;
    out_q.delete();
    acc_cnt = 0;
  endtask

  task automatic send(input logic [16:0] w[$]);
    logic acc;
    int unsigned budget;
    foreach (w[i]) begin
      in_valid = 1'b1;
      in_data  = w[i];
      budget   = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        tick();
        budget++;
      end while (!acc && budget < 100);
      if (!acc) check("send_timeout", 32'(budget), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [16:0] exp[$]);
    int unsigned budget = 0;
    while (out_q.size() < exp.size() && budget < 100) begin
      tick();
      budget++;
    end
    repeat (2) tick();
    check({name, "_count"}, 32'(out_q.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < out_q.size()) check({name, "_word"}, 32'(out_q[i]), 32'(exp[i]));
    end
  endtask

  task automatic check_status(input string name, input int unsigned blk, input int unsigned wrd,
                              input logic d, input logic e);
    check({name, "_blk"},  32'(blk_count),  blk);
    check({name, "_word"}, 32'(word_count), wrd);
    check({name, "_done"}, 32'(done), 32'(d));
    check({name, "_err"},  32'(err),  32'(e));
  endtask

  task automatic soft_reset_test(input logic use_rst);
    do_reset();
    out_ready = 1'b0;
    send('{17'h00005, 17'h00111, 17'h00222});
    check("pre_clr_word", 32'(word_count), 32'd2);
    check("pre_clr_ov", 32'(out_valid), 32'd1);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    check("clr_ov", 32'(out_valid), 32'd0);
    check("clr_ir", 32'(in_ready), 32'd1);
    check_status("clr", 0, 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    send('{17'h00001, 17'h00333, TOK});
    expect_out("post_clr", '{17'h00001, 17'h00333, TOK});
    check_status("post_clr", 1, 1, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic        vld;
    logic [16:0] din;
    logic        exp_rdy;
    logic        exp_ov;
    logic [16:0] exp_od;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 17'h00003, 1'b1, 1'b0, 17'h00000};
    tbl[1] = '{1'b1, 17'h0000A, 1'b1, 1'b1, 17'h00003};
    tbl[2] = '{1'b1, 17'h0000B, 1'b1, 1'b1, 17'h0000A};
    tbl[3] = '{1'b1, 17'h0000C, 1'b1, 1'b1, 17'h0000B};
    tbl[4] = '{1'b1, 17'h00002, 1'b1, 1'b1, 17'h0000C};
    tbl[5] = '{1'b1, 17'h0000D, 1'b1, 1'b1, 17'h00002};
    tbl[6] = '{1'b1, 17'h0000E, 1'b1, 1'b1, 17'h0000D};
    tbl[7] = '{1'b1, TOK,       1'b1, 1'b1, 17'h0000E};
    tbl[8] = '{1'b0, 17'h00000, 1'b0, 1'b1, TOK};
    tbl[9] = '{1'b0, 17'h00000, 1'b0, 1'b0, 17'h00000};

    out_ready = 1'b1;
    do_reset();
    check("rst_ir", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check_status("rst", 0, 0, 1'b0, 1'b0);

    // Basic stream, one word per cycle, one cycle of latency.
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].din;
      #1;
      check("tbl_in_ready", 32'(in_ready), 32'(tbl[i].exp_rdy));
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) check("tbl_out_data", 32'(out_data), 32'(tbl[i].exp_od));
      tick();
    end
    check_status("tbl_end", 2, 5, 1'b1, 1'b0);

    // Backpressure: output stalled for 10 cycles.
    do_reset();
    fork
      send('{17'h00003, 17'h0000A, 17'h0000B, 17'h0000C, 17'h00002, 17'h0000D, 17'h0000E, TOK});
      begin
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("bp_accepts", 32'(acc_cnt), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    expect_out("bp", '{17'h00003, 17'h0000A, 17'h0000B, 17'h0000C, 17'h00002, 17'h0000D, 17'h0000E, TOK});
    check_status("bp", 2, 5, 1'b1, 1'b0);

    // Empty blocks.
    do_reset();
    send('{17'h00000, 17'h00000, 17'h00001, 17'h01234, TOK});
    expect_out("zero", '{17'h00000, 17'h00000, 17'h00001, 17'h01234, TOK});
    check_status("zero", 3, 1, 1'b1, 1'b0);

    // Truncated block.
    do_reset();
    send('{17'h00004, 17'h0000A, TOK});
    expect_out("trunc", '{17'h00004, 17'h0000A, TOK});
    check_status("trunc", 0, 1, 1'b1, 1'b1);

    // Stray control word in HDR is dropped.
    do_reset();
    send('{17'h10005, 17'h00001, 17'h00777, TOK});
    expect_out("stray", '{17'h00001, 17'h00777, TOK});
    check_status("stray", 1, 1, 1'b1, 1'b1);

    soft_reset_test(1'b0);
    soft_reset_test(1'b1);

    // clk_en low for 5 cycles mid-stream.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 17'h00003;
    tick();
    in_data = 17'h0000A;
    tick();
    in_data = 17'h0000B;
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("frz_ir", 32'(in_ready), 32'd0);
      check("frz_ov", 32'(out_valid), 32'd0);
      check("frz_word", 32'(word_count), 32'd1);
      tick();
    end
    clk_en = 1'b1;
    #1;
    check("thaw_ov", 32'(out_valid), 32'd1);
    check("thaw_od", 32'(out_data), 32'h0000A);
    check("thaw_ir", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    send('{17'h0000B, 17'h0000C, TOK});
    expect_out("thaw", '{17'h00003, 17'h0000A, 17'h0000B, 17'h0000C, TOK});
    check_status("thaw", 1, 3, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
